// File: rtl/router_pkg.sv
// Shared constants and the check-combine helper for the router register stage.
package router_pkg;

  // Check modes
  localparam int unsigned CHK_XOR = 0;
  localparam int unsigned CHK_SUM = 1;

  // Default geometry of the 1x3 router
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 2;
  localparam int unsigned DEF_NUM_CH = 3;

  // Header layout: destination in the low bits, payload length directly above it
  localparam int unsigned HDR_ADDR_LSB = 0;

  // Widest word the combine helper carries; callers truncate to their width
  localparam int unsigned CHK_MAX_W = 64;

  // Fold one word into the running check: XOR parity or sum with carry discarded
  function automatic logic [CHK_MAX_W-1:0] chk_combine(
    input logic [CHK_MAX_W-1:0] acc,
    input logic [CHK_MAX_W-1:0] word,
    input int unsigned          mode
  );
    if (mode == CHK_SUM) begin
      chk_combine = acc + word;
    end else begin
      chk_combine = acc ^ word;
    end
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Packet check accumulator, payload counter and end-of-packet error compare.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned CHK_MODE = CHK_XOR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_detect_add,
  input  logic              i_lfd_state,
  input  logic              i_ld_state,
  input  logic              i_full_state,
  input  logic              i_pkt_valid,
  input  logic              i_parity_done,
  input  logic [DATA_W-1:0] i_hdr_reg,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [DATA_W-1:0] i_pkt_chk,
  output logic              o_err,
  output logic              o_err_len
);

  localparam int unsigned LEN_W = DATA_W - ADDR_W;

  logic [DATA_W-1:0] r_chk_int;
  logic [LEN_W-1:0]  r_pay_cnt;
  logic              r_err;
  logic              r_err_len;
  logic              w_take;
  logic              w_cnt_max;

  // A payload word is taken once, in ld_state; the full_state replay is not counted
  assign w_take    = i_ld_state & i_pkt_valid & ~i_full_state;
  assign w_cnt_max = &r_pay_cnt;

  // Running check over header and payload, plus saturating payload count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_chk_int <= '0;
      r_pay_cnt <= '0;
    end else if (i_detect_add) begin
      r_chk_int <= '0;
      r_pay_cnt <= '0;
    end else if (i_lfd_state) begin
      r_chk_int <= DATA_W'(chk_combine(CHK_MAX_W'(r_chk_int), CHK_MAX_W'(i_hdr_reg), CHK_MODE));
    end else if (w_take) begin
      r_chk_int <= DATA_W'(chk_combine(CHK_MAX_W'(r_chk_int), CHK_MAX_W'(i_data_in), CHK_MODE));
      if (!w_cnt_max) begin
        r_pay_cnt <= r_pay_cnt + LEN_W'(1);
      end
    end
  end

  // Compare accumulated check and length once the check word is in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err     <= 1'b0;
      r_err_len <= 1'b0;
    end else if (i_detect_add) begin
      r_err     <= 1'b0;
      r_err_len <= 1'b0;
    end else if (i_parity_done) begin
      r_err     <= (r_chk_int != i_pkt_chk);
      r_err_len <= (r_pay_cnt != i_hdr_reg[DATA_W-1:ADDR_W]);
    end
  end

  assign o_err     = r_err;
  assign o_err_len = r_err_len;

endmodule

// File: rtl/router_reg_gen.sv
// Router packet register stage: header latch, FIFO write data, check and error flags.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned CHK_MODE = CHK_XOR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic [NUM_CH-1:0] dest_onehot,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              err_len,
  output logic              err_addr
);

  localparam int unsigned SEL_W = ADDR_W + 1;

  // Reject parameter sets the header format cannot express
  generate
    if (NUM_CH == 0 || NUM_CH > (2 ** ADDR_W) || ADDR_W >= DATA_W || DATA_W > CHK_MAX_W) begin : g_bad_param
      $error("router_reg_gen: illegal DATA_W/ADDR_W/NUM_CH combination");
    end
  endgenerate

  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_pkt_chk;
  logic [NUM_CH-1:0] r_dest;
  logic              r_err_addr;
  logic              r_low_pkt_valid;
  logic              r_parity_done;

  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_ok;
  logic              w_hdr_ok;
  logic              w_hdr_bad;
  logic [NUM_CH-1:0] w_dest;
  logic              w_pd_set;

  // Header decode of the incoming word
  assign w_addr    = data_in[HDR_ADDR_LSB +: ADDR_W];
  assign w_addr_ok = (SEL_W'(w_addr) < SEL_W'(NUM_CH));
  assign w_hdr_ok  = detect_add & pkt_valid & w_addr_ok;
  assign w_hdr_bad = detect_add & pkt_valid & ~w_addr_ok;
  assign w_dest    = NUM_CH'(1) << w_addr;
  assign w_pd_set  = (ld_state & ~pkt_valid & ~fifo_full) |
                     (laf_state & r_low_pkt_valid & ~r_parity_done);

  // Latch a legal header and its destination; an illegal one only raises a pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hdr      <= '0;
      r_dest     <= '0;
      r_err_addr <= 1'b0;
    end else begin
      r_err_addr <= w_hdr_bad;
      if (w_hdr_ok) begin
        r_hdr  <= data_in;
        r_dest <= w_dest;
      end
    end
  end

  // FIFO write word: header, live payload, or the word parked while the FIFO was full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dout <= '0;
    end else if (lfd_state) begin
      r_dout <= r_hdr;
    end else if (ld_state && !fifo_full) begin
      r_dout <= data_in;
    end else if (laf_state) begin
      r_dout <= r_hold;
    end
  end

  // Park the word offered while the FIFO is full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= '0;
    end else if (ld_state && fifo_full) begin
      r_hold <= data_in;
    end
  end

  // Capture the check word as pkt_valid falls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pkt_chk <= '0;
    end else if (ld_state && !pkt_valid) begin
      r_pkt_chk <= data_in;
    end
  end

  // End-of-packet markers: low_pkt_valid and parity_done, clears take priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_low_pkt_valid <= 1'b0;
      r_parity_done   <= 1'b0;
    end else begin
      if (rst_int_reg) begin
        r_low_pkt_valid <= 1'b0;
      end else if (ld_state && !pkt_valid) begin
        r_low_pkt_valid <= 1'b1;
      end
      if (detect_add) begin
        r_parity_done <= 1'b0;
      end else if (w_pd_set) begin
        r_parity_done <= 1'b1;
      end
    end
  end

  router_chk_acc #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CHK_MODE(CHK_MODE)
  ) u_chk_acc (
    .clk          (clk),
    .resetn       (resetn),
    .i_detect_add (detect_add),
    .i_lfd_state  (lfd_state),
    .i_ld_state   (ld_state),
    .i_full_state (full_state),
    .i_pkt_valid  (pkt_valid),
    .i_parity_done(r_parity_done),
    .i_hdr_reg    (r_hdr),
    .i_data_in    (data_in),
    .i_pkt_chk    (r_pkt_chk),
    .o_err        (err),
    .o_err_len    (err_len)
  );

  assign dout          = r_dout;
  assign dest_onehot   = r_dest;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err_addr      = r_err_addr;

endmodule

// File: tb/tb_router_reg_gen.sv
// Bench for router_reg_gen: XOR and SUM instances driven by the same stimulus.
module tb_router_reg_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned NC = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic          detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;

  logic [DW-1:0] dout0, dout1;
  logic [NC-1:0] dest0, dest1;
  logic          pd0, pd1, lpv0, lpv1, err0, err1, el0, el1, ea0, ea1;

  always #5 clk = ~clk;

  router_reg_gen #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .CHK_MODE(0)) u_xor (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout0), .dest_onehot(dest0),
    .parity_done(pd0), .low_pkt_valid(lpv0), .err(err0), .err_len(el0), .err_addr(ea0)
  );

  router_reg_gen #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .CHK_MODE(1)) u_sum (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout1), .dest_onehot(dest1),
    .parity_done(pd1), .low_pkt_valid(lpv1), .err(err1), .err_len(el1), .err_addr(ea1)
  );

  typedef struct {
    logic [DW-1:0] hdr;
    int            npay;
    int            seed;
    logic [DW-1:0] flip;
    int            full_at;
    logic [NC-1:0] dest;
    logic          err;
    logic          elen;
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout;
  logic [DW-1:0] hold_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    fifo_full   = 1'b0;
  endtask

  // Push this cycle's expected FIFO word, clock, then pop and compare both instances
  task automatic step();
    logic [DW-1:0] e;
    exp_q.push_back(exp_dout);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("dout_xor", 32'(dout0), 32'(e));
    chk("dout_sum", 32'(dout1), 32'(e));
  endtask

  // One packet through detect_add, lfd, payload loads, check word and rst_int_reg
  task automatic send_pkt(input logic [DW-1:0] hdr, input logic [DW-1:0] pay[$],
                          input logic [DW-1:0] chkw, input int full_at);
    clr_in(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
    step();
    chk("err_clr_xor", 32'(err0), 0);
    chk("err_clr_sum", 32'(err1), 0);
    chk("elen_clr", 32'(el0), 0);
    chk("pd_clr", 32'(pd0), 0);
    clr_in(); lfd_state = 1'b1; pkt_valid = 1'b1;
    data_in = (pay.size() != 0) ? pay[0] : chkw;
    exp_dout = hdr;
    step();
    for (int i = 0; i < pay.size(); i++) begin
      clr_in(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = pay[i];
      if (i == full_at) begin
        fifo_full = 1'b1;
        hold_m    = pay[i];
        step();
        repeat (2) begin
          clr_in(); full_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1; data_in = pay[i];
          step();
        end
        clr_in(); laf_state = 1'b1; pkt_valid = 1'b1; data_in = pay[i];
        exp_dout = hold_m;
        step();
      end else begin
        exp_dout = pay[i];
        step();
      end
    end
    clr_in(); ld_state = 1'b1; pkt_valid = 1'b0; data_in = chkw;
    exp_dout = chkw;
    step();
    chk("parity_done", 32'(pd0), 1);
    chk("low_pkt_valid_set", 32'(lpv0), 1);
    clr_in(); rst_int_reg = 1'b1;
    step();
    chk("low_pkt_valid_clr", 32'(lpv0), 0);
    clr_in();
  endtask

  vec_t          tbl[6];
  logic [DW-1:0] pay[$];
  logic [DW-1:0] c;

  initial begin
    // hdr, npay, seed, flip, full_at, dest, err, err_len
    tbl = '{
      '{8'h49, 18, 1, 8'h00, -1, 3'b010, 1'b0, 1'b0},
      '{8'h49, 18, 2, 8'h01, -1, 3'b010, 1'b1, 1'b0},
      '{8'h19,  5, 3, 8'h00, -1, 3'b010, 1'b0, 1'b1},
      '{8'h49, 18, 4, 8'h00,  2, 3'b010, 1'b0, 1'b0},
      '{8'h02,  0, 5, 8'h00, -1, 3'b100, 1'b0, 1'b0},
      '{8'h0C,  3, 6, 8'h00, -1, 3'b001, 1'b0, 1'b0}
    };

    resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; clr_in();
    exp_dout = '0;
    step();
    chk("rst_dest", 32'(dest0), 0);
    chk("rst_pd", 32'(pd0), 0);
    chk("rst_lpv", 32'(lpv0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_elen", 32'(el0), 0);
    chk("rst_eaddr", 32'(ea0), 0);
    chk("rst_err_sum", 32'(err1), 0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      pay.delete();
      c = tbl[i].hdr;
      for (int j = 0; j < tbl[i].npay; j++) begin
        pay.push_back(8'(tbl[i].seed * 53 + j * 29 + 7));
        c = c ^ pay[j];
      end
      send_pkt(tbl[i].hdr, pay, c ^ tbl[i].flip, tbl[i].full_at);
      chk($sformatf("v%0d_dest", i), 32'(dest0), 32'(tbl[i].dest));
      chk($sformatf("v%0d_err", i), 32'(err0), 32'(tbl[i].err));
      chk($sformatf("v%0d_err_len", i), 32'(el0), 32'(tbl[i].elen));
      step();
      chk($sformatf("v%0d_err_hold", i), 32'(err0), 32'(tbl[i].err));
    end

    // Additive checksum instance: 0x0E + 0xF0 + 0x20 + 0x05 = 0x23 mod 256
    pay = '{8'hF0, 8'h20, 8'h05};
    send_pkt(8'h0E, pay, 8'h23, -1);
    chk("sum_dest", 32'(dest1), 32'h4);
    chk("sum_err_ok", 32'(err1), 0);
    chk("sum_elen_ok", 32'(el1), 0);
    send_pkt(8'h0E, pay, 8'h24, -1);
    chk("sum_err_bad", 32'(err1), 1);

    // Illegal address: one-cycle pulse, header and destination keep 0x0E / ch2
    clr_in(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h4B;
    step();
    chk("eaddr_pulse", 32'(ea0), 1);
    chk("eaddr_dest_hold", 32'(dest0), 32'h4);
    clr_in(); pkt_valid = 1'b0;
    step();
    chk("eaddr_drop", 32'(ea0), 0);
    lfd_state = 1'b1;
    exp_dout = 8'h0E;
    step();
    clr_in();
    step();

    // Reset between clock edges in the middle of a payload
    clr_in(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h49;
    step();
    clr_in(); lfd_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h11;
    exp_dout = 8'h49;
    step();
    clr_in(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h11;
    exp_dout = 8'h11;
    step();
    clr_in(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h22;
    #2 resetn = 1'b0;
    #1;
    chk("async_dout", 32'(dout0), 0);
    chk("async_dest", 32'(dest0), 0);
    chk("async_pd", 32'(pd0), 0);
    chk("async_lpv", 32'(lpv0), 0);
    chk("async_err", 32'(err0), 0);
    chk("async_eaddr", 32'(ea0), 0);
    exp_dout = '0;
    clr_in(); pkt_valid = 1'b0;
    step();
    resetn = 1'b1;
    step();

    pay.delete();
    c = 8'h0D;
    for (int j = 0; j < 3; j++) begin
      pay.push_back(8'(j * 71 + 3));
      c = c ^ pay[j];
    end
    send_pkt(8'h0D, pay, c, -1);
    chk("post_rst_dest", 32'(dest0), 32'h2);
    chk("post_rst_err", 32'(err0), 0);
    chk("post_rst_elen", 32'(el0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
- Parametrised packet register/check stage of the 1xN router, sitting between the router FSM and the per-destination FIFOs.
- Latches the header and forwards header, payload and check word to the FIFO write path. Holds one word while the target FIFO is full.
- Accumulates a selectable packet check (XOR parity or additive checksum) and flags check, length and address errors.
- Generalises the 1x3 register block to any data width, address width, channel count and check mode.

Parameters:
- DATA_W, 8: data word width.
- ADDR_W, 2: header destination field width, header[ADDR_W-1:0]; payload length is header[DATA_W-1:ADDR_W].
- NUM_CH, 3: number of destinations; legal addresses 0..NUM_CH-1. Elaboration error if NUM_CH > 2**ADDR_W or ADDR_W >= DATA_W.
- CHK_MODE, 0: 0 = XOR parity; 1 = sum mod 2**DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  source word valid; deasserts on the check word.
- data_in  in  DATA_W  source word.
- fifo_full  in  1  selected FIFO full.
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  router FSM state decodes.
- rst_int_reg  in  1  clears low_pkt_valid.
- dout  out  DATA_W  word to FIFO.
- dest_onehot  out  NUM_CH  decoded destination of latched header.
- parity_done  out  1  check word consumed.
- low_pkt_valid  out  1  pkt_valid has fallen during load.
- err  out  1  check mismatch.
- err_len  out  1  payload count differs from header length.
- err_addr  out  1  one-cycle pulse: illegal address.

Behaviour:
- Reset: asynchronous; while resetn=0 every register and every output is 0.
- All outputs are registered; one clk latency from qualifying inputs.
- addr_ok = data_in[ADDR_W-1:0] < NUM_CH.
- hdr_reg, dest_onehot: load data_in and the one-hot decode on detect_add & pkt_valid & addr_ok.
- err_addr: 1 for one cycle on detect_add & pkt_valid & !addr_ok. In that case hdr_reg and dest_onehot hold.
- dout, first matching term wins:
  - lfd_state: hdr_reg.
  - ld_state & !fifo_full: data_in.
  - laf_state: hold_reg.
  - otherwise: hold.
- hold_reg: loads data_in on ld_state & fifo_full.
- chk_int and pay_cnt (width DATA_W-ADDR_W, saturating):
  - detect_add: clear both.
  - lfd_state: chk_int combines hdr_reg.
  - ld_state & pkt_valid & !full_state: chk_int combines data_in; pay_cnt += 1.
  - Combine is XOR, or add with carry discarded, per CHK_MODE.
  - A held word is counted exactly once.
- pkt_chk: loads data_in on ld_state & !pkt_valid.
- low_pkt_valid: set on ld_state & !pkt_valid; cleared on rst_int_reg; clear wins if both occur.
- parity_done:
  - Set on (ld_state & !pkt_valid & !fifo_full) or (laf_state & low_pkt_valid & !parity_done).
  - Cleared on detect_add; clear wins.
- err, err_len:
  - Cleared on detect_add.
  - While parity_done=1: err <= (chk_int != pkt_chk); err_len <= (pay_cnt != hdr_reg[DATA_W-1:ADDR_W]).
  - Both are valid from the cycle after parity_done rises and hold until the next detect_add.
- Header length 0: no payload; the check word follows lfd directly.
- Reset mid-packet: all state lost; the next packet starts clean at detect_add.

Decomposition:
- Shared package router_pkg:
  - CHK_XOR/CHK_SUM constants.
  - Header field width/position localparams.
  - function chk_combine(acc, word, mode).
- Sub-module router_chk_acc: chk_int accumulator, pay_cnt counter, err/err_len compare.
- Datapath muxing (dout, hold_reg, hdr_reg) stays in router_reg_gen.

Test Plan:
1. Defaults. Header 0x49 (len 18, addr 1), 18 payload words, correct XOR parity, fifo_full=0 -> dest_onehot=3'b010. dout shows header then payload, one cycle after each state. parity_done=1 the cycle after the parity word. err=0, err_len=0.
2. Same packet, parity word XOR 0x01 -> err=1 one cycle after parity_done; err returns to 0 at next detect_add.
3. Header 0x19 (len 6), only 5 payload words, then correct parity -> err=0, err_len=1.
4. fifo_full=1 during 3rd payload ld_state, then 2 cycles full_state, then laf_state -> hold_reg appears on dout one cycle after laf_state. Word counted once; err=0, err_len=0.
5. CHK_MODE=1. Header 0x0E (len 3, addr 2), payload 0xF0, 0x20, 0x05, check 0x23 -> dest_onehot=3'b100, err=0. Repeat with check 0x24 -> err=1.
6. Two cases:
   - Header 0x4B (addr 3) with detect_add -> err_addr pulses once; hdr_reg and dest_onehot unchanged.
   - resetn=0 mid-payload between clock edges -> all outputs 0 immediately. Next good packet passes with err=0.
